// File: rtl/usb_bus_initiator.sv
// Host side of the 8-bit multiplexed USB register bus: one ALEn address phase, then CEn + RDn/WRn data phases.
// Define USB_BUS_INITIATOR_BURST_EN to honour cmd_len; otherwise every command moves exactly one byte.
module usb_bus_initiator #(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic        clk_usb,
   input  logic        reset_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [7:0]  cmd_addr,
   input  logic [15:0] cmd_len,
   input  logic [7:0]  wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic [7:0]  usb_addr,
   output logic        usb_alen,
   output logic        usb_cen,
   output logic        usb_rdn,
   output logic        usb_wrn,
   output logic [7:0]  usb_d_o,
   output logic        usb_d_oe,
   input  logic [7:0]  usb_d_i
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_A_SET  = 3'd1;
   localparam logic [2:0] S_A_STB  = 3'd2;
   localparam logic [2:0] S_A_HLD  = 3'd3;
   localparam logic [2:0] S_D_WAIT = 3'd4;
   localparam logic [2:0] S_D_SET  = 3'd5;
   localparam logic [2:0] S_D_STB  = 3'd6;
   localparam logic [2:0] S_D_HLD  = 3'd7;

   localparam logic [7:0] SETUP_M1 = 8'(SETUP_CYC - 1);
   localparam logic [7:0] PULSE_M1 = 8'(PULSE_CYC - 1);
   localparam logic [7:0] HOLD_M1  = 8'(HOLD_CYC - 1);

   logic [2:0] r_state;
   logic [7:0] r_phase;
   logic       r_write;
   logic [7:0] r_usb_addr;
   logic [7:0] r_usb_d_o;
   logic       r_usb_d_oe;
   logic       r_alen;
   logic       r_cen;
   logic       r_rdn;
   logic       r_wrn;
   logic [7:0] r_rd_data;
   logic       r_rd_valid;
   logic       r_wr_ready;
   logic       r_busy;
   logic       r_cmd_ready;

   logic [2:0] w_next_state;
   logic [7:0] w_entry_phase;
   logic       w_cmd_fire;
   logic       w_wr_fire;
   logic       w_phase_done;
   logic       w_last_byte;
   logic       w_capture;
   logic       w_ns_data;

   assign w_cmd_fire   = cmd_valid & r_cmd_ready;
   assign w_wr_fire    = wr_valid & r_wr_ready;
   assign w_phase_done = (r_phase == 8'd0);
   assign w_capture    = (r_state == S_D_STB) & w_phase_done & ~r_write;
   assign w_ns_data    = (w_next_state inside {S_D_SET, S_D_STB, S_D_HLD});

`ifdef USB_BUS_INITIATOR_BURST_EN
   logic [15:0] r_remain;

   assign w_last_byte = (r_remain == 16'd1);

   // Burst bytes share the single address phase; only the data phases repeat.
   always_ff @(posedge clk_usb) begin
      if (reset_i) begin
         r_remain <= 16'd0;
      end else if (w_cmd_fire) begin
         r_remain <= (cmd_len == 16'd0) ? 16'd1 : cmd_len;
      end else if ((r_state == S_D_HLD) && w_phase_done) begin
         r_remain <= r_remain - 16'd1;
      end
   end
`else
   logic w_unused_len;

   assign w_unused_len = ^cmd_len;
   assign w_last_byte  = 1'b1;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_cmd_fire) w_next_state = S_A_SET;
         S_A_SET:  if (w_phase_done) w_next_state = S_A_STB;
         S_A_STB:  if (w_phase_done) w_next_state = S_A_HLD;
         S_A_HLD:  if (w_phase_done) w_next_state = S_D_WAIT;
         S_D_WAIT: if (!r_write || w_wr_fire) w_next_state = S_D_SET;
         S_D_SET:  if (w_phase_done) w_next_state = S_D_STB;
         S_D_STB:  if (w_phase_done) w_next_state = S_D_HLD;
         S_D_HLD:  if (w_phase_done) w_next_state = w_last_byte ? S_IDLE : S_D_WAIT;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_entry_phase = 8'd0;
      case (w_next_state)
         S_A_SET, S_D_SET: w_entry_phase = SETUP_M1;
         S_A_STB, S_D_STB: w_entry_phase = PULSE_M1;
         S_A_HLD, S_D_HLD: w_entry_phase = HOLD_M1;
         default:          w_entry_phase = 8'd0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   // Bus outputs are decoded from the next state so they are registered yet aligned with the state.
   always_ff @(posedge clk_usb) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_phase     <= 8'd0;
         r_write     <= 1'b0;
         r_usb_addr  <= 8'd0;
         r_usb_d_o   <= 8'd0;
         r_usb_d_oe  <= 1'b0;
         r_alen      <= 1'b1;
         r_cen       <= 1'b1;
         r_rdn       <= 1'b1;
         r_wrn       <= 1'b1;
         r_rd_data   <= 8'd0;
         r_rd_valid  <= 1'b0;
         r_wr_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_cmd_ready <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_next_state != r_state) begin
            r_phase <= w_entry_phase;
         end else if (!w_phase_done) begin
            r_phase <= r_phase - 8'd1;
         end
         if (w_cmd_fire) begin
            r_write    <= cmd_write;
            r_usb_addr <= cmd_addr;
         end
         if (w_wr_fire) begin
            r_usb_d_o <= wr_data;
         end
         if (w_capture) begin
            r_rd_data <= usb_d_i;
         end
         r_rd_valid  <= w_capture;
         r_alen      <= (w_next_state != S_A_STB);
         r_cen       <= ~w_ns_data;
         r_wrn       <= ~((w_next_state == S_D_STB) & r_write);
         r_rdn       <= ~((w_next_state == S_D_STB) & ~r_write);
         r_usb_d_oe  <= w_ns_data & r_write;
         r_wr_ready  <= (w_next_state == S_D_WAIT) & r_write;
         r_busy      <= (w_next_state != S_IDLE);
         r_cmd_ready <= (w_next_state == S_IDLE);
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign wr_ready  = r_wr_ready;
   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign busy      = r_busy;
   assign usb_addr  = r_usb_addr;
   assign usb_alen  = r_alen;
   assign usb_cen   = r_cen;
   assign usb_rdn   = r_rdn;
   assign usb_wrn   = r_wrn;
   assign usb_d_o   = r_usb_d_o;
   assign usb_d_oe  = r_usb_d_oe;

endmodule

// File: tb/tb_usb_bus_initiator.sv
// Bench for usb_bus_initiator: a register-device model on the bus plus a transaction-level expectation model.
// Follows USB_BUS_INITIATOR_BURST_EN the same way the design does.
module tb_usb_bus_initiator;

   localparam int SETUP    = 1;
   localparam int PULSE    = 2;
   localparam int HOLD     = 1;
   localparam int ADDR_CYC = SETUP + PULSE + HOLD;
   localparam int BYTE_CYC = 1 + SETUP + PULSE + HOLD;
`ifdef USB_BUS_INITIATOR_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic        clk_usb;
   logic        reset_i;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_len;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        busy;
   logic [7:0]  usb_addr;
   logic        usb_alen;
   logic        usb_cen;
   logic        usb_rdn;
   logic        usb_wrn;
   logic [7:0]  usb_d_o;
   logic        usb_d_oe;
   logic [7:0]  usb_d_i;

   usb_bus_initiator #(.SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD)) dut (
      .clk_usb  (clk_usb),
      .reset_i  (reset_i),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .busy     (busy),
      .usb_addr (usb_addr),
      .usb_alen (usb_alen),
      .usb_cen  (usb_cen),
      .usb_rdn  (usb_rdn),
      .usb_wrn  (usb_wrn),
      .usb_d_o  (usb_d_o),
      .usb_d_oe (usb_d_oe),
      .usb_d_i  (usb_d_i)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] dev_mem [256];
   logic [7:0] ref_mem [256];
   logic [7:0] tx_q [$];
   logic [7:0] wr_log [$];
   logic [7:0] rd_log [$];
   bit         feed_gate = 1'b1;

   int m_alen_pulses, m_alen_low, m_wrn_pulses, m_wrn_low, m_rdn_pulses, m_rdn_low;
   int m_cen_pulses, m_rdv, m_busy_cyc, m_accepts, m_proto_err, m_wrrdy_cyc;
   logic [7:0] m_alen_addr;
   logic p_alen = 1'b1, p_wrn = 1'b1, p_rdn = 1'b1, p_cen = 1'b1;

   initial clk_usb = 1'b0;
   always #5 clk_usb = ~clk_usb;
   always @(posedge clk_usb) cyc <= cyc + 1;

   // The device only returns the true register value while RDn is low, so mistimed capture shows up.
   assign usb_d_i = usb_rdn ? ~dev_mem[usb_addr] : dev_mem[usb_addr];

   always @(negedge clk_usb) begin
      if (!usb_alen) m_alen_low++;
      if (!usb_alen && p_alen) begin
         m_alen_pulses++;
         m_alen_addr = usb_addr;
      end
      if (!usb_wrn && p_wrn) begin
         m_wrn_pulses++;
         wr_log.push_back(usb_d_o);
      end
      if (!usb_wrn) begin
         m_wrn_low++;
         if (!(usb_d_oe && !usb_cen)) m_proto_err++;
         dev_mem[usb_addr] = usb_d_o;
      end
      if (!usb_rdn && p_rdn) m_rdn_pulses++;
      if (!usb_rdn) begin
         m_rdn_low++;
         if (usb_d_oe || usb_cen) m_proto_err++;
      end
      if (!usb_cen && p_cen) m_cen_pulses++;
      if (!usb_alen && !usb_cen) m_proto_err++;
      if (cmd_ready && busy) m_proto_err++;
      if (rd_valid) begin
         m_rdv++;
         rd_log.push_back(rd_data);
      end
      if (busy) m_busy_cyc++;
      if (wr_ready) m_wrrdy_cyc++;
      if (cmd_valid && cmd_ready) m_accepts++;
      p_alen = usb_alen;
      p_wrn  = usb_wrn;
      p_rdn  = usb_rdn;
      p_cen  = usb_cen;
   end

   // Write-stream source: presents the head of tx_q and pops it once the handshake has happened.
   initial begin : feeder
      bit fire;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      forever begin
         @(negedge clk_usb);
         fire = wr_valid && wr_ready;
         @(posedge clk_usb);
         #1;
         if (fire && tx_q.size() > 0) void'(tx_q.pop_front());
         wr_valid = feed_gate && (tx_q.size() > 0);
         wr_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(negedge clk_usb);
      #1;
   endtask

   task automatic clear_mon();
      m_alen_pulses = 0; m_alen_low = 0; m_wrn_pulses = 0; m_wrn_low = 0;
      m_rdn_pulses = 0; m_rdn_low = 0; m_cen_pulses = 0; m_rdv = 0;
      m_busy_cyc = 0; m_accepts = 0; m_proto_err = 0; m_wrrdy_cyc = 0;
      wr_log.delete();
      rd_log.delete();
   endtask

   task automatic issue(input bit wr, input logic [7:0] addr, input logic [15:0] len,
                        input bit keep, output int c0);
      bit ok = 1'b0;
      tick();
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_valid = 1'b1;
      for (int i = 0; i < 400 && !ok; i++) begin
         if (cmd_ready === 1'b1) ok = 1'b1;
         else tick();
      end
      check("cmd_accept", ok, 1'b1);
      @(posedge clk_usb);
      #1;
      c0 = cyc;
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic wait_ready(output int edge_n);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         tick();
         if (cmd_ready === 1'b1) ok = 1'b1;
      end
      check("ready_return", ok, 1'b1);
      edge_n = cyc + 1;
   endtask

   function automatic int exp_latency(input int n_bytes);
      return ADDR_CYC + n_bytes * BYTE_CYC + 1;
   endfunction

   initial begin
      int c0, c1, r_edge, n, bad, acc0;
      bit found, wr;
      logic [7:0] addr, b;
      logic [15:0] len;
      logic [7:0] exp_bytes [$];

      for (int i = 0; i < 256; i++) begin
         dev_mem[i] = 8'($urandom);
         ref_mem[i] = dev_mem[i];
      end
      reset_i = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 16'h0;
      repeat (3) tick();
      check("rst_alen", usb_alen, 1'b1);
      check("rst_cen", usb_cen, 1'b1);
      check("rst_rdn", usb_rdn, 1'b1);
      check("rst_wrn", usb_wrn, 1'b1);
      check("rst_d_oe", usb_d_oe, 1'b0);
      check("rst_d_o", usb_d_o, 8'h00);
      check("rst_addr", usb_addr, 8'h00);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_wr_ready", wr_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      reset_i = 1'b0;
      tick();
      check("rel_cmd_ready", cmd_ready, 1'b1);

      // 1: single write with data pre-held
      tx_q.push_back(8'h5C);
      repeat (2) tick();
      clear_mon();
      issue(1'b1, 8'h2A, 16'd1, 1'b0, c0);
      wait_ready(r_edge);
      ref_mem[8'h2A] = 8'h5C;
      check("w1_latency", r_edge - c0, exp_latency(1));
      check("w1_busy_cyc", m_busy_cyc, exp_latency(1) - 1);
      check("w1_alen_pulses", m_alen_pulses, 1);
      check("w1_alen_low", m_alen_low, PULSE);
      check("w1_alen_addr", m_alen_addr, 8'h2A);
      check("w1_wrn_pulses", m_wrn_pulses, 1);
      check("w1_wrn_low", m_wrn_low, PULSE);
      check("w1_wr_byte", (wr_log.size() > 0) ? wr_log[0] : 8'hxx, 8'h5C);
      check("w1_rdn_pulses", m_rdn_pulses, 0);
      check("w1_proto", m_proto_err, 0);

      // 2: single read
      dev_mem[8'h03] = 8'hA7;
      ref_mem[8'h03] = 8'hA7;
      clear_mon();
      issue(1'b0, 8'h03, 16'd1, 1'b0, c0);
      wait_ready(r_edge);
      check("r2_latency", r_edge - c0, exp_latency(1));
      check("r2_rdv_pulses", m_rdv, 1);
      check("r2_rd_data", rd_data, 8'hA7);
      check("r2_rdn_low", m_rdn_low, PULSE);
      check("r2_wrn_pulses", m_wrn_pulses, 0);
      check("r2_proto", m_proto_err, 0);

      // 3: four-byte write burst (single byte when bursts are not built)
      for (int i = 1; i <= 4; i++) tx_q.push_back(8'(i));
      repeat (2) tick();
      clear_mon();
      issue(1'b1, 8'h10, 16'd4, 1'b0, c0);
      wait_ready(r_edge);
      n = BURST ? 4 : 1;
      ref_mem[8'h10] = 8'(n);
      check("b3_latency", r_edge - c0, exp_latency(n));
      check("b3_alen_pulses", m_alen_pulses, 1);
      check("b3_wrn_pulses", m_wrn_pulses, n);
      check("b3_cen_pulses", m_cen_pulses, n);
      check("b3_log_size", wr_log.size(), n);
      for (int i = 0; i < wr_log.size() && i < n; i++) check("b3_byte", wr_log[i], 8'(i + 1));
      check("b3_left_in_stream", tx_q.size(), 4 - n);
      check("b3_dev_reg", dev_mem[8'h10], ref_mem[8'h10]);
      check("b3_proto", m_proto_err, 0);
      tx_q.delete();
      repeat (2) tick();

      // 4: write stalled in the data wait for five cycles
      feed_gate = 1'b0;
      tx_q.push_back(8'hC3);
      clear_mon();
      issue(1'b1, 8'h20, 16'd1, 1'b0, c0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         tick();
         if (wr_ready === 1'b1) found = 1'b1;
      end
      check("s4_wr_ready_seen", found, 1'b1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (usb_cen !== 1'b1 || usb_wrn !== 1'b1 || busy !== 1'b1 || wr_ready !== 1'b1) bad++;
      end
      check("s4_stall_idle_bus", bad, 0);
      feed_gate = 1'b1;
      wait_ready(r_edge);
      ref_mem[8'h20] = 8'hC3;
      check("s4_stall_len_ok", m_wrrdy_cyc >= 6, 1'b1);
      check("s4_busy_cyc", m_busy_cyc, ADDR_CYC + BYTE_CYC - 1 + m_wrrdy_cyc);
      check("s4_wrn_pulses", m_wrn_pulses, 1);
      check("s4_wr_byte", (wr_log.size() > 0) ? wr_log[0] : 8'hxx, 8'hC3);

      // 5: reset during the read strobe
      clear_mon();
      issue(1'b0, 8'h05, 16'd1, 1'b0, c0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         tick();
         if (usb_rdn === 1'b0) found = 1'b1;
      end
      check("x5_rdn_seen", found, 1'b1);
      reset_i = 1'b1;
      tick();
      check("x5_rdn", usb_rdn, 1'b1);
      check("x5_cen", usb_cen, 1'b1);
      check("x5_d_oe", usb_d_oe, 1'b0);
      check("x5_busy", busy, 1'b0);
      check("x5_cmd_ready", cmd_ready, 1'b0);
      tick();
      reset_i = 1'b0;
      tick();
      check("x5_cmd_ready_rel", cmd_ready, 1'b1);
      check("x5_no_rd_valid", m_rdv, 0);

      // 6: zero-length read with a second command held valid while busy
      clear_mon();
      issue(1'b0, 8'h31, 16'd0, 1'b1, c0);
      cmd_addr = 8'h32;
      acc0 = m_accepts;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         if (m_accepts > acc0) found = 1'b1;
      end
      check("z6_second_accept", found, 1'b1);
      check("z6_accept_edge", (cyc + 1) - c0, exp_latency(1));
      check("z6_rdv_first", m_rdv, 1);
      check("z6_rdn_first", m_rdn_pulses, 1);
      check("z6_first_byte", (rd_log.size() > 0) ? rd_log[0] : 8'hxx, ref_mem[8'h31]);
      @(posedge clk_usb);
      #1;
      c1 = cyc;
      cmd_valid = 1'b0;
      wait_ready(r_edge);
      check("z6_second_latency", r_edge - c1, exp_latency(1));
      check("z6_rd_data", rd_data, ref_mem[8'h32]);
      check("z6_rdv_total", m_rdv, 2);

      // Random mix of reads and writes against the register-file model
      for (int t = 0; t < 24; t++) begin
         wr   = 1'($urandom_range(0, 1));
         addr = 8'h40 + 8'($urandom_range(0, 7));
         len  = 16'($urandom_range(0, 3));
         n    = BURST ? ((len == 16'd0) ? 1 : int'(len)) : 1;
         exp_bytes.delete();
         if (wr) begin
            for (int i = 0; i < n; i++) begin
               b = 8'($urandom);
               exp_bytes.push_back(b);
               tx_q.push_back(b);
            end
         end
         clear_mon();
         issue(wr, addr, len, 1'b0, c0);
         wait_ready(r_edge);
         check("rnd_latency", r_edge - c0, exp_latency(n));
         check("rnd_alen_pulses", m_alen_pulses, 1);
         check("rnd_proto", m_proto_err, 0);
         if (wr) begin
            check("rnd_wrn_pulses", m_wrn_pulses, n);
            check("rnd_stream_empty", tx_q.size(), 0);
            for (int i = 0; i < wr_log.size() && i < n; i++) check("rnd_wr_byte", wr_log[i], exp_bytes[i]);
            ref_mem[addr] = exp_bytes[n - 1];
            check("rnd_dev_reg", dev_mem[addr], ref_mem[addr]);
         end else begin
            check("rnd_rdn_pulses", m_rdn_pulses, n);
            check("rnd_rdv_pulses", m_rdv, n);
            for (int i = 0; i < rd_log.size() && i < n; i++) check("rnd_rd_byte", rd_log[i], ref_mem[addr]);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
